// File: rtl/intra16_mode_ctrl_pkg.sv
// Shared types and constants for the Intra 16x16 mode-decision controller.
//   - mode encodings, SAD sentinel, DC fallback pixel value
//   - FSM state enum, pixel row / block vector types
//   - best-mode selection helper
package intra_pkg;

  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 8;

  localparam logic [1:0]  MODE_V     = 2'd0;
  localparam logic [1:0]  MODE_H     = 2'd1;
  localparam logic [1:0]  MODE_DC    = 2'd2;
  localparam logic [15:0] SAD_MAX    = 16'hFFFF;
  localparam logic [7:0]  DC_DEFAULT = 8'd128;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0]           row_t;  // one 16-pixel row
  typedef logic [NUM_LANES*NUM_LANES-1:0][VEC_W-1:0] blk_t;  // 16x16 raster block

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRED,
    ST_WAIT,
    ST_FETCH,
    ST_DECIDE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] sad;
  } pick_t;

  // Minimum SAD over legal modes. DC is always legal, so it seeds the search;
  // H then V are tried with <= so ties resolve to the lower mode number.
  function automatic pick_t pick_best(input logic [15:0] sv, input logic [15:0] sh,
                                      input logic [15:0] sdc, input logic v_ok,
                                      input logic h_ok);
    pick_t p;
    p.mode = MODE_DC;
    p.sad  = sdc;
    if (h_ok && (sh <= p.sad)) begin
      p.mode = MODE_H;
      p.sad  = sh;
    end
    if (v_ok && (sv <= p.sad)) begin
      p.mode = MODE_V;
      p.sad  = sv;
    end
    return p;
  endfunction

endpackage

// File: rtl/intra16_mode_ctrl_if.sv
// Original-row fetch handshake between the mode controller and the MB buffer.
//   orig_req   controller -> buffer  row request, held until accepted
//   orig_row   controller -> buffer  requested row 0..15
//   orig_valid buffer -> controller  orig_pix carries the requested row
//   orig_pix   buffer -> controller  16 pixels, index = column
interface intra16_mode_ctrl_if;
  import intra_pkg::*;

  logic       orig_req;
  logic [3:0] orig_row;
  logic       orig_valid;
  row_t       orig_pix;

  modport master (output orig_req, output orig_row, input orig_valid, input orig_pix);
  modport slave  (input orig_req, input orig_row, output orig_valid, output orig_pix);
endinterface

// File: rtl/intra16_mode_ctrl_sad_row16.sv
// sad_row16: combinational sum of absolute differences over one 16-pixel row.
//   a, b : 16 x 8-bit pixels
//   sum  : 12-bit row SAD (max 16*255 = 4080)
module sad_row16
  import intra_pkg::*;
(
  input  row_t        a,
  input  row_t        b,
  output logic [11:0] sum
);

  logic [NUM_LANES-1:0][VEC_W-1:0] ad;

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    logic [VEC_W:0] d;
    // 9-bit difference; sign bit selects negation, magnitude always fits 8 bits
    assign d     = {1'b0, a[c]} - {1'b0, b[c]};
    assign ad[c] = d[VEC_W] ? VEC_W'(-d) : d[VEC_W-1:0];
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < NUM_LANES; c++) sum = sum + {4'b0, ad[c]};
  end

endmodule

// File: rtl/intra16_mode_ctrl.sv
// intra16_mode_ctrl: per-macroblock sequencer for the Intra 16x16 luma predictor.
//   clk, reset           clock, async active-high reset
//   start                begin one MB (accepted only in IDLE)
//   top/left_avail,_in   neighbour availability and raw pixels, latched at start
//   pred_en              one-cycle predictor fire
//   pred_top/left        substituted neighbours, held for the whole op
//   vpred/hpred/dcpred   predictor outputs, raster order (col + 16*row)
//   orig                 original-row fetch handshake (master side)
//   busy, done           op in progress / one-cycle results-valid pulse
//   best_mode, best_sad  winning legal mode and its SAD
//   sad_v/sad_h/sad_dc   per-mode SAD, 16'hFFFF for an unavailable mode
module intra16_mode_ctrl
  import intra_pkg::*;
#(
  parameter int PRED_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 top_avail,
  input  logic                 left_avail,
  input  row_t                 top_in,
  input  row_t                 left_in,
  output logic                 pred_en,
  output row_t                 pred_top,
  output row_t                 pred_left,
  input  blk_t                 vpred,
  input  blk_t                 hpred,
  input  blk_t                 dcpred,
  intra16_mode_ctrl_if.master  orig,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           best_mode,
  output logic [15:0]          best_sad,
  output logic [15:0]          sad_v,
  output logic [15:0]          sad_h,
  output logic [15:0]          sad_dc
);

  state_t      state;
  logic        top_ok, left_ok;
  logic [15:0] acc_v, acc_h, acc_dc;
  logic [15:0] wait_cnt;

  // Neighbour substitution: a missing side borrows the other; with neither,
  // both sides are flat 128 so every mode predicts mid-grey.
  row_t sub_top, sub_left;
  always_comb begin
    sub_top  = {NUM_LANES{DC_DEFAULT}};
    sub_left = {NUM_LANES{DC_DEFAULT}};
    case ({top_avail, left_avail})
      2'b11: begin sub_top = top_in;  sub_left = left_in; end
      2'b10: begin sub_top = top_in;  sub_left = top_in;  end
      2'b01: begin sub_top = left_in; sub_left = left_in; end
      default: ;
    endcase
  end

  // Predicted row matching the currently requested original row
  row_t vrow, hrow, dcrow;
  always_comb begin
    vrow  = '0;
    hrow  = '0;
    dcrow = '0;
    for (int c = 0; c < NUM_LANES; c++) begin
      vrow[c]  = vpred[{orig.orig_row, 4'(c)}];
      hrow[c]  = hpred[{orig.orig_row, 4'(c)}];
      dcrow[c] = dcpred[{orig.orig_row, 4'(c)}];
    end
  end

  logic [11:0] rs_v, rs_h, rs_dc;
  sad_row16 u_sad_v  (.a(orig.orig_pix), .b(vrow),  .sum(rs_v));
  sad_row16 u_sad_h  (.a(orig.orig_pix), .b(hrow),  .sum(rs_h));
  sad_row16 u_sad_dc (.a(orig.orig_pix), .b(dcrow), .sum(rs_dc));

  logic [15:0] eff_v, eff_h;
  pick_t       pick;
  assign eff_v = top_ok  ? acc_v : SAD_MAX;
  assign eff_h = left_ok ? acc_h : SAD_MAX;
  assign pick  = pick_best(eff_v, eff_h, acc_dc, top_ok, left_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      top_ok        <= 1'b0;
      left_ok       <= 1'b0;
      acc_v         <= '0;
      acc_h         <= '0;
      acc_dc        <= '0;
      wait_cnt      <= '0;
      pred_en       <= 1'b0;
      pred_top      <= '0;
      pred_left     <= '0;
      orig.orig_req <= 1'b0;
      orig.orig_row <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      best_mode     <= '0;
      best_sad      <= '0;
      sad_v         <= '0;
      sad_h         <= '0;
      sad_dc        <= '0;
    end else begin
      pred_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            top_ok    <= top_avail;
            left_ok   <= left_avail;
            pred_top  <= sub_top;
            pred_left <= sub_left;
            acc_v     <= '0;
            acc_h     <= '0;
            acc_dc    <= '0;
            best_mode <= '0;
            best_sad  <= '0;
            sad_v     <= '0;
            sad_h     <= '0;
            sad_dc    <= '0;
            busy      <= 1'b1;
            pred_en   <= 1'b1;
            state     <= ST_PRED;
          end
        end
        ST_PRED: begin
          wait_cnt <= '0;
          if (PRED_LAT <= 1) begin
            orig.orig_req <= 1'b1;
            orig.orig_row <= '0;
            state         <= ST_FETCH;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Holds for PRED_LAT-1 cycles (counter runs 0..PRED_LAT-2)
          if (wait_cnt == 16'(PRED_LAT - 2)) begin
            orig.orig_req <= 1'b1;
            orig.orig_row <= '0;
            state         <= ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_FETCH: begin
          if (orig.orig_valid) begin
            acc_v  <= acc_v  + 16'(rs_v);
            acc_h  <= acc_h  + 16'(rs_h);
            acc_dc <= acc_dc + 16'(rs_dc);
            if (orig.orig_row == 4'd15) begin
              orig.orig_req <= 1'b0;
              state         <= ST_DECIDE;
            end else begin
              orig.orig_row <= orig.orig_row + 4'd1;
            end
          end
        end
        ST_DECIDE: begin
          sad_v     <= eff_v;
          sad_h     <= eff_h;
          sad_dc    <= acc_dc;
          best_mode <= pick.mode;
          best_sad  <= pick.sad;
          done      <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra16_mode_ctrl.sv
// Directed bench for intra16_mode_ctrl: table of MB configurations with
// hand-computed SADs, plus stall, start-while-busy and mid-op reset sequences.
module tb_intra16_mode_ctrl;
  import intra_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        top_avail, left_avail;
  row_t        top_in, left_in;
  logic        pred_en;
  row_t        pred_top, pred_left;
  blk_t        vpred, hpred, dcpred;
  logic        busy, done;
  logic [1:0]  best_mode;
  logic [15:0] best_sad, sad_v, sad_h, sad_dc;

  intra16_mode_ctrl_if bus ();

  intra16_mode_ctrl #(.PRED_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .top_avail(top_avail), .left_avail(left_avail),
    .top_in(top_in), .left_in(left_in),
    .pred_en(pred_en), .pred_top(pred_top), .pred_left(pred_left),
    .vpred(vpred), .hpred(hpred), .dcpred(dcpred),
    .orig(bus),
    .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad),
    .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
  );

  always #5 clk = ~clk;

  // Behavioural 16x16 predictor, one-cycle latency after pred_en
  int dc_sum;
  always_comb begin
    dc_sum = 0;
    for (int c = 0; c < 16; c++) dc_sum = dc_sum + int'(pred_top[c]) + int'(pred_left[c]);
  end
  always @(posedge clk) begin
    if (pred_en) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          vpred[c + 16*r]  <= pred_top[c];
          hpred[c + 16*r]  <= pred_left[r];
          dcpred[c + 16*r] <= 8'((dc_sum + 16) >> 5);
        end
    end
  end

  typedef struct {
    bit          top_av, left_av, top_ramp;
    logic [7:0]  top_val, left_val, orig_val, orig_step;
    logic [1:0]  mode;
    logic [15:0] sv, sh, sdc, bsad;
    logic [7:0]  pt15, pl0;
  } vec_t;

  vec_t vecs[7];
  logic [15:0][15:0][7:0] orig_mb;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run one MB. orig rows come from the bench's own accepted-row count.
  task automatic run_mb(input vec_t v, input bit stall, input bit poke, input int abort_row,
                        output int done_cyc, output bit row_err, output bit pulse_ok);
    int cyc, acc, scnt;
    bit hit;
    top_avail  = v.top_av;
    left_avail = v.left_av;
    for (int c = 0; c < 16; c++) begin
      top_in[c]  = v.top_ramp ? 8'(c) : v.top_val;
      left_in[c] = v.left_val;
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        orig_mb[r][c] = v.orig_val + 8'(int'(v.orig_step) * r);
    done_cyc = -1; row_err = 0; pulse_ok = 0; acc = 0; scnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      if (cyc == 1) pulse_ok = busy && pred_en;
      if (poke) start = (cyc == 5) || done;
      if (done) begin done_cyc = cyc; break; end
      if (abort_row >= 0 && bus.orig_req && acc == abort_row) break;
      if (bus.orig_req) begin
        if (bus.orig_row != 4'(acc)) row_err = 1;
        if (stall && (acc == 0 || acc == 7 || acc == 15) && scnt < 3) begin
          bus.orig_valid = 1'b0;
          scnt++;
        end else bus.orig_valid = 1'b1;
      end else bus.orig_valid = 1'b1;
      bus.orig_pix = orig_mb[4'(acc)];
      hit = bus.orig_req && bus.orig_valid;
      @(posedge clk);
      if (hit) begin acc++; scnt = 0; end
      cyc++;
    end
    if (done_cyc >= 0) begin
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v, input bit stall,
                               input bit poke, input int exp_cyc);
    int dc; bit re, po;
    run_mb(v, stall, poke, -1, dc, re, po);
    chk({tag, ".done_cyc"}, 32'(dc), 32'(exp_cyc));
    chk({tag, ".pred_pulse"}, 32'(po), 32'd1);
    chk({tag, ".row_seq"}, 32'(re), 32'd0);
    chk({tag, ".best_mode"}, 32'(best_mode), 32'(v.mode));
    chk({tag, ".best_sad"}, 32'(best_sad), 32'(v.bsad));
    chk({tag, ".sad_v"}, 32'(sad_v), 32'(v.sv));
    chk({tag, ".sad_h"}, 32'(sad_h), 32'(v.sh));
    chk({tag, ".sad_dc"}, 32'(sad_dc), 32'(v.sdc));
    chk({tag, ".pred_top15"}, 32'(pred_top[15]), 32'(v.pt15));
    chk({tag, ".pred_left0"}, 32'(pred_left[0]), 32'(v.pl0));
    @(negedge clk);
    chk({tag, ".busy_after"}, 32'(busy), 32'd0);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dc; bit re, po;
    //          tav lav ramp top left orig step mode sv        sh        sdc       bsad   pt15 pl0
    vecs[0] = '{1, 1, 0, 10,  200, 10,  0, 2'd0, 16'd0,     16'd48640, 16'd24320, 16'd0,    10,  200};
    vecs[1] = '{1, 1, 1, 0,   50,  50,  0, 2'd1, 16'd10880, 16'd0,     16'd5376,  16'd0,    15,  50};
    vecs[2] = '{0, 1, 0, 7,   100, 100, 0, 2'd1, 16'hFFFF,  16'd0,     16'd0,     16'd0,    100, 100};
    vecs[3] = '{0, 0, 0, 3,   9,   128, 0, 2'd2, 16'hFFFF,  16'hFFFF,  16'd0,     16'd0,    128, 128};
    vecs[4] = '{1, 0, 0, 60,  5,   60,  0, 2'd0, 16'd0,     16'hFFFF,  16'd0,     16'd0,    60,  60};
    vecs[5] = '{1, 1, 0, 20,  40,  0,   4, 2'd2, 16'd4480,  16'd4480,  16'd4096,  16'd4096, 20,  40};
    vecs[6] = '{1, 1, 0, 0,   255, 255, 0, 2'd1, 16'd65280, 16'd0,     16'd32512, 16'd0,    0,   255};

    reset = 1'b1; start = 1'b0; top_avail = 0; left_avail = 0;
    top_in = '0; left_in = '0; bus.orig_valid = 1'b1; bus.orig_pix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.pred_en", 32'(pred_en), 0);
    chk("rst.orig_req", 32'(bus.orig_req), 0);
    chk("rst.best_mode", 32'(best_mode), 0);
    chk("rst.best_sad", 32'(best_sad), 0);
    chk("rst.sad_v", 32'(sad_v), 0);
    chk("rst.sad_h", 32'(sad_h), 0);
    chk("rst.sad_dc", 32'(sad_dc), 0);
    chk("rst.pred_top0", 32'(pred_top[0]), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_and_check($sformatf("vec%0d", i), vecs[i], 0, 0, 19);

    // Three stall cycles ahead of rows 0, 7 and 15
    run_and_check("stall", vecs[0], 1, 0, 28);
    // start pulsed mid-op and again during done: both ignored
    run_and_check("poke", vecs[5], 0, 1, 19);

    // Abort during row 8 of one MB, then a clean MB must be uncontaminated
    run_mb(vecs[1], 0, 0, 8, dc, re, po);
    reset = 1'b1;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    chk("abort.orig_req", 32'(bus.orig_req), 0);
    chk("abort.sad_h", 32'(sad_h), 0);
    @(negedge clk);
    reset = 1'b0;
    bus.orig_valid = 1'b1;
    run_and_check("post_abort", vecs[0], 0, 0, 19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
